// File: rtl/booth_mult_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | booth_mult_seq : iterative radix-4 Booth multiplier, one group per clock,   |
// |                  signed/unsigned, optional skipping of low Booth groups.    |
// | Revision       : 1.0                                                        |
// +----------------------------------------------------------------------------+
module booth_mult_seq #(
    parameter int WIDTH    = 8,
    parameter int APPROX_W = $clog2(WIDTH/2+2)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    input  logic [APPROX_W-1:0]  approx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int G     = WIDTH/2 + 1;
    localparam int E     = WIDTH + 2;
    localparam int ACC   = 2*WIDTH + 4;
    localparam int IDX_W = $clog2(G + 1);
    localparam logic [IDX_W-1:0] C_LAST = IDX_W'(G - 1);
    localparam logic [IDX_W-1:0] C_ALL  = IDX_W'(G);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [E-1:0]       a_ext_q, a_ext_d;
    logic [E-1:0]       b_ext_q, b_ext_d;
    logic [ACC-1:0]     acc_q, acc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic [IDX_W-1:0]   w_skip;
    logic [ACC-1:0]     w_a_acc;
    logic [2:0]         w_trip;
    logic [ACC-1:0]     w_mag;
    logic [ACC-1:0]     w_pp;

    always_comb begin
        if (int'(approx) >= G) begin
            w_skip = C_ALL;
        end else begin
            w_skip = IDX_W'(approx);
        end
    end

    // Booth triple for the current group; the appended 0 supplies b_ext[-1].
    assign w_a_acc = {{(ACC-E){a_ext_q[E-1]}}, a_ext_q};
    assign w_trip  = 3'({b_ext_q, 1'b0} >> {idx_q, 1'b0});

    always_comb begin
        case (w_trip)
            3'b001, 3'b010: w_mag = w_a_acc;
            3'b011:         w_mag = w_a_acc << 1;
            3'b100:         w_mag = -(w_a_acc << 1);
            3'b101, 3'b110: w_mag = -w_a_acc;
            default:        w_mag = '0;
        endcase
    end

    assign w_pp = w_mag << {idx_q, 1'b0};

    always_comb begin
        state_d   = state_q;
        a_ext_d   = a_ext_q;
        b_ext_d   = b_ext_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_ext_d = {{2{signed_mode & a[WIDTH-1]}}, a};
                    b_ext_d = {{2{signed_mode & b[WIDTH-1]}}, b};
                    acc_d   = '0;
                    idx_d   = w_skip;
                    state_d = (w_skip == C_ALL) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                acc_d = acc_q + w_pp;
                idx_d = idx_q + 1'b1;
                if (idx_q == C_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_ext_q <= '0;
            b_ext_q <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_ext_q <= a_ext_d;
            b_ext_q <= b_ext_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
        end
    end

    assign product = acc_q[2*WIDTH-1:0];

endmodule
`default_nettype wire
